int_service: RTL and testbench
==============================

Name: int_service

Overview:
- CPU-side consumer of the interrupt controller's `interupt[4:0]` request vector.
- At instruction boundaries it arbitrates pending requests by two-level priority (IP) and natural order, then issues a vectored call request to the core.
- It tracks the in-service priority levels until RETI and pulses hardware flag-clear strobes back to the controller's TCON path.

Parameters:
- VEC_BASE, 16'h0003, vector address of source 0.
- VEC_STRIDE, 8, address step between consecutive source vectors.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- interupt  input  5  pending requests, already IE/EA-masked; bit0 IE0, bit1 TF0, bit2 IE1, bit3 TF1, bit4 RI|TI.
- IP  input  5  priority per source: 1 = high, 0 = low.
- boundary  input  1  core at instruction boundary and may accept an interrupt this cycle.
- reti  input  1  one-cycle pulse: RETI executed.
- ack  input  1  core has pushed PC and taken `vector`.
- int_req  output  1  vectored call request.
- vector  output  16  call target, valid while `int_req`=1.
- clr_flag  output  5  one-cycle strobe clearing the hardware-cleared flag of the serviced source.
- in_service  output  2  bit1 high level in service, bit0 low level in service.

Behaviour:
- Reset (asynchronous, `rst_n`=0) values:
  - `int_req`=0, `vector`=0, `clr_flag`=0, `in_service`=2'b00.
  - FSM goes to IDLE, latched index/level cleared.
- FSM states: IDLE, REQ.
- Eligibility, combinational on the `interupt` and `IP` inputs:
  - `in_service[1]`=1: nothing is eligible.
  - `in_service`=2'b01: only sources with `IP`=1 are eligible.
  - `in_service`=2'b00: all pending sources are eligible.
- Arbitration among eligible sources:
  - Any high-priority source beats every low-priority source.
  - Within a level, the lowest index wins (0 > 1 > 2 > 3 > 4).
- IDLE -> REQ: on a clock where `boundary`=1, `reti`=0 and at least one source is eligible.
  - Latch winner index n and its level.
  - Next cycle: `int_req`=1 and `vector`=VEC_BASE+VEC_STRIDE*n (16-bit, no overflow for n<=4).
  - Latency from sampled boundary to `int_req` is 1 cycle.
- RETI blocking: `boundary` with `reti`=1 in the same cycle accepts nothing. The next interrupt waits for a later boundary, i.e. at least one instruction executes after RETI.
- REQ state:
  - `int_req` and `vector` hold stable until `ack`=1. `ack` seen in IDLE is ignored.
  - Withdrawal of the latched source while in REQ does not cancel the request; it completes with the latched vector.
  - Higher-priority arrivals during REQ do not re-arbitrate.
- On the `ack` clock, registered, taking effect the next cycle:
  - Set `in_service[level]`.
  - Pulse `clr_flag[n]` for exactly 1 cycle if n<=3.
  - n=4 (serial) gives no pulse; software clears RI/TI.
  - Deassert `int_req` and return to IDLE.
- `reti` handling, in any state:
  - Clears the highest set `in_service` bit: bit1 if set, else bit0.
  - `reti` with `in_service`=00 has no effect.
- Simultaneous `ack` and `reti` in REQ: apply the RETI clear first, then set the bit for the acked level.
- Nesting limits:
  - Low may be preempted by high.
  - High cannot be preempted.
  - Same-level nesting is impossible.
- `clr_flag` is zero except for the single strobe cycle. `vector` retains its last value in IDLE.
- Reset mid-REQ aborts the request immediately; no `clr_flag` pulse is issued.

Test Plan:
- Reset, then `interupt`=5'b00010, `IP`=0, `boundary` pulse -> next cycle `int_req`=1, `vector`=16'h000B. `ack` -> `clr_flag`=5'b00010 for 1 cycle, `in_service`=01.
- `interupt`=5'b10001, `IP`=5'b10000, boundary -> `vector`=16'h0023 (serial high wins over IE0 low). After `ack`: `clr_flag`=0, `in_service`=10.
- `in_service`=01 (low ISR active); low request IE1 at boundary -> no `int_req`. Set `IP[2]`=1 -> `vector`=16'h0013, `in_service`=11. `reti` -> 01, `reti` -> 00.
- `boundary` and `reti` in the same cycle with TF1 pending -> no request that cycle. Next boundary -> `vector`=16'h001B.
- In REQ, drop `interupt` to 0 and hold `ack`=0 for 5 cycles -> `int_req` and `vector` stable. `ack` then completes normally.
- Assert `rst_n`=0 while `int_req`=1 -> all outputs 0 asynchronously; no `clr_flag` pulse after release.

Source files
------------

// File: rtl/int_service.sv
// int_service: arbitrates masked interrupt requests by two-level priority and tracks in-service levels
module int_service #(
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  interupt,
    input  logic [4:0]  IP,
    input  logic        boundary,
    input  logic        reti,
    input  logic        ack,
    output logic        int_req,
    output logic [15:0] vector,
    output logic [4:0]  clr_flag,
    output logic [1:0]  in_service
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_next;
    logic [4:0] elig, hi, pick;
    logic [2:0] win, idx;
    logic       lvl, accept, done;
    logic [1:0] is_next;

    assign int_req = (state == REQ);
    assign done    = (state == REQ) && ack;

    // Eligibility, winner selection, next state and next in-service levels
    always_comb begin
        elig = in_service[1] ? 5'b0 : in_service[0] ? (interupt & IP) : interupt;
        hi = elig & IP;
        pick = |hi ? hi : elig;
        win = 3'd0;
        for (int i = 4; i >= 0; i--) if (pick[i]) win = 3'(i);
        accept = (state == IDLE) && boundary && !reti && |elig;
        state_next = accept ? REQ : done ? IDLE : state;
        is_next = reti ? (in_service[1] ? {1'b0, in_service[0]} : 2'b00) : in_service;
        if (done) is_next[lvl] = 1'b1;
    end

    // State, latched winner, vector, flag-clear strobe and in-service registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            lvl        <= 1'b0;
            vector     <= 16'd0;
            clr_flag   <= 5'd0;
            in_service <= 2'b00;
        end else begin
            state      <= state_next;
            in_service <= is_next;
            clr_flag   <= (done && idx != 3'd4) ? (5'd1 << idx) : 5'd0;
            if (accept) begin
                idx    <= win;
                lvl    <= |hi;
                vector <= VEC_BASE + 16'(VEC_STRIDE * win);
            end
        end
    end
endmodule

// File: tb/tb_int_service.sv
// tb_int_service: directed vector table plus randomized run against a stack-based reference model
module tb_int_service;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  interupt, IP;
    logic        boundary, reti, ack;
    logic        int_req;
    logic [15:0] vector;
    logic [4:0]  clr_flag;
    logic [1:0]  in_service;

    int errors = 0;
    int checks = 0;

    int_service dut (
        .clk(clk), .rst_n(rst_n), .interupt(interupt), .IP(IP),
        .boundary(boundary), .reti(reti), .ack(ack), .int_req(int_req),
        .vector(vector), .clr_flag(clr_flag), .in_service(in_service)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  irq;
        logic [4:0]  ip;
        logic        b, r, a;
        logic        req;
        logic [15:0] vec;
        logic [4:0]  clr;
        logic [1:0]  is;
    } vec_t;
    vec_t tbl[$];

    // Reference model: the in-service levels are a nesting stack
    bit          stk[$];
    bit          m_req, m_lvl;
    int          m_src;
    logic [15:0] m_vec;
    logic [4:0]  m_clr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] i, input logic [4:0] p, input logic b, input logic r, input logic a);
        interupt = i; IP = p; boundary = b; reti = r; ack = a;
    endtask

    function automatic int pick_src(input logic [4:0] irq, input logic [4:0] ip, output bit lv);
        lv = 1'b0;
        if (stk.size() > 0 && stk[$] == 1'b1) return -1;
        for (int l = 1; l >= 0; l--) begin
            if (stk.size() > 0 && l == 0) continue;
            for (int s = 0; s < 5; s++)
                if (irq[s] && ip[s] == l[0]) begin
                    lv = l[0];
                    return s;
                end
        end
        return -1;
    endfunction

    function automatic logic [1:0] model_is();
        logic [1:0] r = 2'b00;
        foreach (stk[k]) r[stk[k]] = 1'b1;
        return r;
    endfunction

    task automatic model_clock();
        bit lv;
        int s;
        s = pick_src(interupt, IP, lv);
        m_clr = 5'd0;
        if (m_req && ack) begin
            if (reti && stk.size() > 0) void'(stk.pop_back());
            stk.push_back(m_lvl);
            if (m_src < 4) m_clr = 5'd1 << m_src;
            m_req = 1'b0;
        end else begin
            if (reti && stk.size() > 0) void'(stk.pop_back());
            if (!m_req && boundary && !reti && s >= 0) begin
                m_req = 1'b1;
                m_src = s;
                m_lvl = lv;
                m_vec = 16'h0003 + 16'(8 * s);
            end
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_req = 1'b0; m_lvl = 1'b0; m_src = 0; m_vec = 16'd0; m_clr = 5'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tbl.push_back('{5'b00010, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000B, 5'b00000, 2'b00});
        tbl.push_back('{5'b00010, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h000B, 5'b00010, 2'b01});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000B, 5'b00000, 2'b01});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000B, 5'b00000, 2'b00});
        tbl.push_back('{5'b10001, 5'b10000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0023, 5'b00000, 2'b00});
        tbl.push_back('{5'b10001, 5'b10000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0023, 5'b00000, 2'b10});
        tbl.push_back('{5'b00100, 5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0023, 5'b00000, 2'b10});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0023, 5'b00000, 2'b00});
        tbl.push_back('{5'b00001, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 5'b00000, 2'b00});
        tbl.push_back('{5'b00001, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 5'b00001, 2'b00 | 2'b01});
        tbl.push_back('{5'b00100, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 5'b00000, 2'b01});
        tbl.push_back('{5'b00100, 5'b00100, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0013, 5'b00000, 2'b01});
        tbl.push_back('{5'b00100, 5'b00100, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0013, 5'b00100, 2'b11});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0013, 5'b00000, 2'b01});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0013, 5'b00000, 2'b00});
        tbl.push_back('{5'b01000, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0013, 5'b00000, 2'b00});
        tbl.push_back('{5'b01000, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h001B, 5'b00000, 2'b00});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h001B, 5'b00000, 2'b00});
        tbl.push_back('{5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h001B, 5'b00000, 2'b00});
        tbl.push_back('{5'b00001, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h001B, 5'b00000, 2'b00});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h001B, 5'b00000, 2'b00});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h001B, 5'b00000, 2'b00});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h001B, 5'b01000, 2'b01});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h001B, 5'b00000, 2'b01});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h001B, 5'b00000, 2'b01});
        tbl.push_back('{5'b00010, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000B, 5'b00000, 2'b01});
        tbl.push_back('{5'b00010, 5'b00010, 1'b0, 1'b1, 1'b1, 1'b0, 16'h000B, 5'b00010, 2'b10});
        tbl.push_back('{5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000B, 5'b00000, 2'b00});

        #12;
        chk("rst_int_req", 32'(int_req), 32'd0);
        chk("rst_vector", 32'(vector), 32'd0);
        chk("rst_clr_flag", 32'(clr_flag), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].irq, tbl[k].ip, tbl[k].b, tbl[k].r, tbl[k].a);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_int_req", k), 32'(int_req), 32'(tbl[k].req));
            chk($sformatf("tbl%0d_vector", k), 32'(vector), 32'(tbl[k].vec));
            chk($sformatf("tbl%0d_clr_flag", k), 32'(clr_flag), 32'(tbl[k].clr));
            chk($sformatf("tbl%0d_in_service", k), 32'(in_service), 32'(tbl[k].is));
        end

        drive(5'b00100, 5'b00000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_int_req", 32'(int_req), 32'd1);
        chk("pre_rst_vector", 32'(vector), 32'h0013);
        drive(5'b00100, 5'b00000, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_int_req", 32'(int_req), 32'd0);
        chk("async_rst_vector", 32'(vector), 32'd0);
        chk("async_rst_clr_flag", 32'(clr_flag), 32'd0);
        chk("async_rst_in_service", 32'(in_service), 32'd0);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            chk("post_rst_int_req", 32'(int_req), 32'd0);
            chk("post_rst_clr_flag", 32'(clr_flag), 32'd0);
            chk("post_rst_in_service", 32'(in_service), 32'd0);
        end

        model_reset();
        for (int c = 0; c < 3000; c++) begin
            drive(5'($urandom), 5'($urandom), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0));
            @(posedge clk);
            model_clock();
            #1;
            chk("rnd_int_req", 32'(int_req), 32'(m_req));
            chk("rnd_vector", 32'(vector), 32'(m_vec));
            chk("rnd_clr_flag", 32'(clr_flag), 32'(m_clr));
            chk("rnd_in_service", 32'(in_service), 32'(model_is()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
